// File: rtl/hazard_detect_unit_if.sv
// Pipeline-side bundle for hazard_detect_unit: ID/EX inputs and stall/flush controls.
// Counter outputs appear only when HAZARD_STATS_EN is defined.
interface hazard_detect_unit_if #(
    parameter int INSTR_W = 32,
    parameter int REG_W   = 5
);
    logic [INSTR_W-1:0] if_id_reg_i;
    logic               rs_used_i;
    logic               rt_used_i;
    logic [REG_W-1:0]   id_ex_regrt_i;
    logic               id_ex_memrd_i;
    logic               branch_taken_i;
    logic               pc_stall_o;
    logic               stallHold_o;
    logic               mux_control_o;
    logic               if_id_flush_o;
`ifdef HAZARD_STATS_EN
    logic [31:0]        stall_cnt_o;
    logic [31:0]        flush_cnt_o;
`endif

    modport master (
        output if_id_reg_i, rs_used_i, rt_used_i, id_ex_regrt_i, id_ex_memrd_i, branch_taken_i,
`ifdef HAZARD_STATS_EN
        input  stall_cnt_o, flush_cnt_o,
`endif
        input  pc_stall_o, stallHold_o, mux_control_o, if_id_flush_o
    );

    modport slave (
        input  if_id_reg_i, rs_used_i, rt_used_i, id_ex_regrt_i, id_ex_memrd_i, branch_taken_i,
`ifdef HAZARD_STATS_EN
        output stall_cnt_o, flush_cnt_o,
`endif
        output pc_stall_o, stallHold_o, mux_control_o, if_id_flush_o
    );
endinterface

// File: rtl/hazard_detect_unit.sv
// Load-use hazard detector with LOAD_LAT-cycle load shadow and branch squash.
// Optional HAZARD_STATS_EN adds saturating stall/flush event counters.
module hazard_detect_unit #(
    parameter int INSTR_W  = 32,
    parameter int REG_W    = 5,
    parameter int RS_LSB   = 21,
    parameter int RT_LSB   = 16,
    parameter int LOAD_LAT = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    hazard_detect_unit_if.slave hd
);

    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic             ex_hit;
    logic             pend_hit;
    logic             hazard;
    logic             flush;
    logic             unused_instr_bits;

    assign rs = hd.if_id_reg_i[RS_LSB +: REG_W];
    assign rt = hd.if_id_reg_i[RT_LSB +: REG_W];
    assign unused_instr_bits = ^hd.if_id_reg_i;

    function automatic logic src_match(
        input logic             v,
        input logic [REG_W-1:0] rd,
        input logic [REG_W-1:0] src_rs,
        input logic [REG_W-1:0] src_rt,
        input logic             use_rs,
        input logic             use_rt
    );
        return v && (rd != '0) && ((use_rs && (rd == src_rs)) || (use_rt && (rd == src_rt)));
    endfunction

    assign ex_hit = src_match(hd.id_ex_memrd_i, hd.id_ex_regrt_i, rs, rt, hd.rs_used_i, hd.rt_used_i);

    // Loads that have left EX but whose data is still not forwardable.
    generate
        if (LOAD_LAT > 1) begin : g_pend
            localparam int DEPTH = LOAD_LAT - 1;

            logic [DEPTH:1]   v_q;
            logic [DEPTH:1]   v_d;
            logic [REG_W-1:0] rd_q [1:DEPTH];
            logic [REG_W-1:0] rd_d [1:DEPTH];

            always_comb begin
                v_d[1]  = hd.id_ex_memrd_i && (hd.id_ex_regrt_i != '0);
                rd_d[1] = hd.id_ex_regrt_i;
                for (int k = 2; k <= DEPTH; k++) begin
                    v_d[k]  = v_q[k-1];
                    rd_d[k] = rd_q[k-1];
                end
            end

            always_comb begin
                pend_hit = 1'b0;
                for (int k = 1; k <= DEPTH; k++) begin
                    if (src_match(v_q[k], rd_q[k], rs, rt, hd.rs_used_i, hd.rt_used_i)) begin
                        pend_hit = 1'b1;
                    end
                end
            end

            always_ff @(posedge clk_i) begin
                if (!rst_i) begin
                    v_q <= '0;
                end else begin
                    v_q <= v_d;
                end
            end

            always_ff @(posedge clk_i) begin
                for (int k = 1; k <= DEPTH; k++) begin
                    rd_q[k] <= rd_d[k];
                end
            end
        end else begin : g_no_pend
            assign pend_hit = 1'b0;
        end
    endgenerate

    // Reset masks everything combinationally so outputs drop in the same cycle.
    assign hazard = rst_i && (ex_hit || pend_hit);
    assign flush  = rst_i && hd.branch_taken_i && !hazard;

    assign hd.pc_stall_o    = hazard;
    assign hd.stallHold_o   = hazard;
    assign hd.mux_control_o = hazard;
    assign hd.if_id_flush_o = flush;

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;
    logic [31:0] flush_cnt_q;
    logic [31:0] flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (hazard && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (flush && (flush_cnt_q != 32'hFFFF_FFFF)) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hd.stall_cnt_o = stall_cnt_q;
    assign hd.flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_detect_unit.sv
// Directed bench: three hazard_detect_unit instances (LOAD_LAT 1/2/3) share one stimulus stream.
module tb_hazard_detect_unit;

    logic clk;
    logic rst_n;

    logic [31:0] instr;
    logic        rs_used;
    logic        rt_used;
    logic [4:0]  ex_rt;
    logic        ex_memrd;
    logic        br_taken;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic       memrd;
        logic [4:0] exrt;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       rsu;
        logic       rtu;
        logic       br;
        logic [2:0] st;  // expected stall, bit k-1 = LOAD_LAT k
        logic [2:0] fl;  // expected flush, same layout
    } vec_t;

    hazard_detect_unit_if #(.INSTR_W(32), .REG_W(5)) if1 ();
    hazard_detect_unit_if #(.INSTR_W(32), .REG_W(5)) if2 ();
    hazard_detect_unit_if #(.INSTR_W(32), .REG_W(5)) if3 ();

    assign if1.if_id_reg_i = instr;    assign if2.if_id_reg_i = instr;    assign if3.if_id_reg_i = instr;
    assign if1.rs_used_i = rs_used;    assign if2.rs_used_i = rs_used;    assign if3.rs_used_i = rs_used;
    assign if1.rt_used_i = rt_used;    assign if2.rt_used_i = rt_used;    assign if3.rt_used_i = rt_used;
    assign if1.id_ex_regrt_i = ex_rt;  assign if2.id_ex_regrt_i = ex_rt;  assign if3.id_ex_regrt_i = ex_rt;
    assign if1.id_ex_memrd_i = ex_memrd; assign if2.id_ex_memrd_i = ex_memrd; assign if3.id_ex_memrd_i = ex_memrd;
    assign if1.branch_taken_i = br_taken; assign if2.branch_taken_i = br_taken; assign if3.branch_taken_i = br_taken;

    hazard_detect_unit #(.LOAD_LAT(1)) u1 (.clk_i(clk), .rst_i(rst_n), .hd(if1.slave));
    hazard_detect_unit #(.LOAD_LAT(2)) u2 (.clk_i(clk), .rst_i(rst_n), .hd(if2.slave));
    hazard_detect_unit #(.LOAD_LAT(3)) u3 (.clk_i(clk), .rst_i(rst_n), .hd(if3.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    function automatic logic [3:0] obs(input int k);
        case (k)
            1:       return {if1.pc_stall_o, if1.stallHold_o, if1.mux_control_o, if1.if_id_flush_o};
            2:       return {if2.pc_stall_o, if2.stallHold_o, if2.mux_control_o, if2.if_id_flush_o};
            default: return {if3.pc_stall_o, if3.stallHold_o, if3.mux_control_o, if3.if_id_flush_o};
        endcase
    endfunction

    function automatic vec_t mk(input logic memrd, input logic [4:0] exrt, input logic [4:0] rs,
                                input logic [4:0] rt, input logic rsu, input logic rtu, input logic br,
                                input logic [2:0] st, input logic [2:0] fl);
        vec_t v;
        v.memrd = memrd; v.exrt = exrt; v.rs = rs; v.rt = rt;
        v.rsu = rsu; v.rtu = rtu; v.br = br; v.st = st; v.fl = fl;
        return v;
    endfunction

    task automatic set_in(input logic memrd, input logic [4:0] exrt, input logic [4:0] rs,
                          input logic [4:0] rt, input logic rsu, input logic rtu, input logic br);
        instr = {6'h23, rs, rt, 16'h0040};
        ex_memrd = memrd; ex_rt = exrt; rs_used = rsu; rt_used = rtu; br_taken = br;
    endtask

    task automatic apply(input vec_t v);
        @(posedge clk);
        #1;
        set_in(v.memrd, v.exrt, v.rs, v.rt, v.rsu, v.rtu, v.br);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply(mk(0, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000));
    endtask

    task automatic test_reset();
        logic [3:0] got;
        rst_n = 1'b0;
        for (int c = 0; c < 2; c++) begin
            apply(mk(1, 5, 5, 5, 1, 1, 1, 3'b000, 3'b000));
            for (int k = 1; k <= 3; k++) begin
                got = obs(k);
                if (got !== 4'b0000) $display("FAIL reset_outputs lat%0d cyc%0d: got %b want 0000", k, c, got);
                else n_pass++;
                n_total++;
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0);
        #1;
        for (int k = 1; k <= 3; k++) begin
            got = obs(k);
            if (got !== 4'b0000) $display("FAIL reset_release lat%0d: got %b want 0000", k, got);
            else n_pass++;
            n_total++;
        end
    endtask

    task automatic test_single_stall();
        vec_t v[$];
        logic [3:0] got, exp;
        v.push_back(mk(1, 5, 5, 2, 1, 0, 0, 3'b111, 3'b000));
        v.push_back(mk(0, 0, 5, 2, 1, 0, 0, 3'b110, 3'b000));
        v.push_back(mk(0, 0, 5, 2, 1, 0, 0, 3'b100, 3'b000));
        v.push_back(mk(0, 0, 5, 2, 1, 0, 0, 3'b000, 3'b000));
        v.push_back(mk(1, 8, 3, 8, 0, 1, 0, 3'b111, 3'b000));
        v.push_back(mk(0, 0, 3, 8, 0, 1, 0, 3'b110, 3'b000));
        v.push_back(mk(0, 0, 3, 8, 0, 1, 0, 3'b100, 3'b000));
        v.push_back(mk(0, 0, 3, 8, 0, 1, 0, 3'b000, 3'b000));
        foreach (v[c]) begin
            apply(v[c]);
            for (int k = 1; k <= 3; k++) begin
                got = obs(k);
                exp = {{3{v[c].st[k-1]}}, v[c].fl[k-1]};
                if (got !== exp) $display("FAIL single_stall cyc%0d lat%0d: got %b want %b", c, k, got, exp);
                else n_pass++;
                n_total++;
            end
        end
    endtask

    task automatic test_zero_unused();
        vec_t v[$];
        logic [3:0] got, exp;
        v.push_back(mk(1, 0, 0, 0, 1, 1, 0, 3'b000, 3'b000));
        v.push_back(mk(0, 0, 0, 0, 1, 1, 0, 3'b000, 3'b000));
        v.push_back(mk(0, 0, 0, 0, 1, 1, 0, 3'b000, 3'b000));
        v.push_back(mk(1, 9, 3, 9, 1, 0, 0, 3'b000, 3'b000));
        v.push_back(mk(0, 0, 3, 9, 0, 1, 0, 3'b110, 3'b000));
        v.push_back(mk(0, 0, 3, 9, 0, 1, 0, 3'b100, 3'b000));
        v.push_back(mk(0, 0, 3, 9, 0, 1, 0, 3'b000, 3'b000));
        foreach (v[c]) begin
            apply(v[c]);
            for (int k = 1; k <= 3; k++) begin
                got = obs(k);
                exp = {{3{v[c].st[k-1]}}, v[c].fl[k-1]};
                if (got !== exp) $display("FAIL zero_unused cyc%0d lat%0d: got %b want %b", c, k, got, exp);
                else n_pass++;
                n_total++;
            end
        end
    endtask

    task automatic test_branch_flush();
        vec_t v[$];
        logic [3:0] got, exp;
        v.push_back(mk(0, 0, 0, 0, 0, 0, 1, 3'b000, 3'b111));
        v.push_back(mk(1, 5, 5, 0, 1, 0, 1, 3'b111, 3'b000));
        v.push_back(mk(0, 0, 5, 0, 1, 0, 1, 3'b110, 3'b001));
        v.push_back(mk(0, 0, 5, 0, 1, 0, 1, 3'b100, 3'b011));
        v.push_back(mk(0, 0, 5, 0, 1, 0, 1, 3'b000, 3'b111));
        v.push_back(mk(0, 0, 5, 0, 1, 0, 0, 3'b000, 3'b000));
        foreach (v[c]) begin
            apply(v[c]);
            for (int k = 1; k <= 3; k++) begin
                got = obs(k);
                exp = {{3{v[c].st[k-1]}}, v[c].fl[k-1]};
                if (got !== exp) $display("FAIL branch_flush cyc%0d lat%0d: got %b want %b", c, k, got, exp);
                else n_pass++;
                n_total++;
            end
        end
    endtask

    task automatic test_back_to_back();
        vec_t v[$];
        logic [3:0] got, exp;
        v.push_back(mk(1, 5, 1, 2, 1, 1, 0, 3'b000, 3'b000));
        v.push_back(mk(1, 6, 5, 6, 1, 1, 0, 3'b111, 3'b000));
        v.push_back(mk(0, 0, 5, 6, 1, 1, 0, 3'b110, 3'b000));
        v.push_back(mk(0, 0, 5, 6, 1, 1, 0, 3'b100, 3'b000));
        v.push_back(mk(0, 0, 5, 6, 1, 1, 0, 3'b000, 3'b000));
        foreach (v[c]) begin
            apply(v[c]);
            for (int k = 1; k <= 3; k++) begin
                got = obs(k);
                exp = {{3{v[c].st[k-1]}}, v[c].fl[k-1]};
                if (got !== exp) $display("FAIL back_to_back cyc%0d lat%0d: got %b want %b", c, k, got, exp);
                else n_pass++;
                n_total++;
            end
        end
    endtask

    task automatic test_reset_mid_stall();
        logic [3:0] got;
        apply(mk(1, 8, 0, 8, 0, 1, 0, 3'b111, 3'b000));
        got = obs(3);
        if (got !== 4'b1110) $display("FAIL mid_reset_stall1: got %b want 1110", got);
        else n_pass++;
        n_total++;
        apply(mk(0, 0, 0, 8, 0, 1, 0, 3'b110, 3'b000));
        got = obs(3);
        if (got !== 4'b1110) $display("FAIL mid_reset_stall2: got %b want 1110", got);
        else n_pass++;
        n_total++;
        rst_n = 1'b0;
        #1;
        got = obs(3);
        if (got !== 4'b0000) $display("FAIL mid_reset_forced: got %b want 0000", got);
        else n_pass++;
        n_total++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        for (int c = 0; c < 2; c++) begin
            for (int k = 1; k <= 3; k++) begin
                got = obs(k);
                if (got !== 4'b0000) $display("FAIL mid_reset_after cyc%0d lat%0d: got %b want 0000", c, k, got);
                else n_pass++;
                n_total++;
            end
            @(posedge clk); #2;
        end
        apply(mk(1, 8, 0, 8, 0, 1, 0, 3'b111, 3'b000));
        got = obs(3);
        if (got !== 4'b1110) $display("FAIL mid_reset_new_load: got %b want 1110", got);
        else n_pass++;
        n_total++;
    endtask

`ifdef HAZARD_STATS_EN
    task automatic test_stats();
        logic [31:0] want_st [1:3];
        logic [31:0] got_st, got_fl;
        want_st[1] = 32'd2; want_st[2] = 32'd4; want_st[3] = 32'd6;
        rst_n = 1'b0;
        idle(1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        apply(mk(1, 5, 5, 0, 1, 0, 0, 3'b111, 3'b000));
        apply(mk(0, 0, 5, 0, 1, 0, 0, 3'b110, 3'b000));
        apply(mk(0, 0, 5, 0, 1, 0, 0, 3'b100, 3'b000));
        idle(1);
        apply(mk(1, 6, 0, 6, 0, 1, 0, 3'b111, 3'b000));
        apply(mk(0, 0, 0, 6, 0, 1, 0, 3'b110, 3'b000));
        apply(mk(0, 0, 0, 6, 0, 1, 0, 3'b100, 3'b000));
        apply(mk(0, 0, 0, 0, 0, 0, 1, 3'b000, 3'b111));
        idle(1);
        for (int k = 1; k <= 3; k++) begin
            got_st = (k == 1) ? if1.stall_cnt_o : (k == 2) ? if2.stall_cnt_o : if3.stall_cnt_o;
            got_fl = (k == 1) ? if1.flush_cnt_o : (k == 2) ? if2.flush_cnt_o : if3.flush_cnt_o;
            if (got_st !== want_st[k]) $display("FAIL stats_stall lat%0d: got %0d want %0d", k, got_st, want_st[k]);
            else n_pass++;
            n_total++;
            if (got_fl !== 32'd1) $display("FAIL stats_flush lat%0d: got %0d want 1", k, got_fl);
            else n_pass++;
            n_total++;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        if (if2.stall_cnt_o !== 32'd0 || if2.flush_cnt_o !== 32'd0)
            $display("FAIL stats_reset: got %0d/%0d want 0/0", if2.stall_cnt_o, if2.flush_cnt_o);
        else n_pass++;
        n_total++;
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0);
        test_reset();
        idle(4);
        test_single_stall();
        idle(4);
        test_zero_unused();
        idle(4);
        test_branch_flush();
        idle(4);
        test_back_to_back();
        idle(4);
        test_reset_mid_stall();
        idle(4);
`ifdef HAZARD_STATS_EN
        test_stats();
        idle(2);
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
